uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal values 1 or 2.
REQ-005 SHALL have parameter PARITY_ODD, default 0, with 0 = even parity and 1 = odd parity; used only with UART_RX_PARITY_EN.
REQ-006 SHALL have port i_clk, input, 1 bit, the only clock; all logic on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-008 SHALL have port i_srx, input, 1 bit, asynchronous serial line, idle high.
REQ-009 SHALL have port o_Rx_data, output, DATA_BITS bits, last received word, LSB = first bit on the line.
REQ-010 SHALL have port o_Rx_valid, output, 1 bit, one-cycle pulse: new word is on o_Rx_data.
REQ-011 SHALL have port o_frame_err, output, 1 bit, qualified by o_Rx_valid: a stop bit sampled low.
REQ-012 SHALL have port o_parity_err, output, 1 bit, qualified by o_Rx_valid: parity mismatch.
REQ-013 SHALL have port o_busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL generate a 16x oversample tick every OSR_DIV = round(CLK_FREQ/(BAUD*16)) clocks (68 at defaults); the tick counter restarts on start-edge detection.
REQ-015 SHALL pass i_srx through a 2-flop synchronizer before any use; both flops reset to 1.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; each bit lasts 16 ticks, and the bit value is the majority of samples 7, 8 and 9.
REQ-017 IDLE: a synchronized 1->0 transition SHALL enter START.
REQ-018 START: a majority-high result SHALL be a false start and return to IDLE with no output pulse; otherwise the FSM SHALL enter DATA.
REQ-019 DATA: SHALL shift DATA_BITS bits LSB-first, then enter PARITY if compiled in, else STOP.
REQ-020 STOP: SHALL check STOP_BITS bits; any stop bit sampled low SHALL set the frame error.
REQ-021 At sample 9 of the final stop bit, o_Rx_valid SHALL pulse for 1 cycle, with o_frame_err and o_parity_err valid in that same cycle.
REQ-022 After the valid pulse, the FSM SHALL go to IDLE if the stop bit was high, else to WAIT_IDLE.
REQ-023 WAIT_IDLE (break / stuck-low line): SHALL stay until the synchronized line is high, then go to IDLE; no further pulses SHALL occur meanwhile.
REQ-024 A frame with a bad stop or bad parity SHALL still deliver its data.
REQ-025 o_Rx_data SHALL hold its value until the next o_Rx_valid; the error flags SHALL be 0 outside the valid cycle.
REQ-026 A start edge immediately after the stop-bit mid-point SHALL be accepted (back-to-back frames with zero idle).
REQ-027 The receiver SHALL tolerate a baud error of at least +/-2% with no data error.

Reset
REQ-028 Asserting i_rst_n low at any time, including mid-frame, SHALL immediately force IDLE, clear all counters, and set o_Rx_data=0, o_Rx_valid=0, o_frame_err=0, o_parity_err=0, o_busy=0.
REQ-029 After reset release, the first frame SHALL be received only from the next valid start edge; a partial frame SHALL NOT be reported.

Configuration
REQ-030 With macro UART_RX_PARITY_EN defined, SHALL expect one parity bit after the data bits, and o_parity_err SHALL flag a mismatch against PARITY_ODD.
REQ-031 Without UART_RX_PARITY_EN, there SHALL be no PARITY state or parity bit in the frame, and o_parity_err SHALL be tied to 0.

Verification
REQ-032 Defaults, 8N1 at 115200 (8680 ns/bit), words 0x00..0xFF: 256 valid pulses, all data matching, no error flags.
REQ-033 i_srx low for 200 ns then high: no o_Rx_valid; o_busy high then low within 1 bit time.
REQ-034 0x55 sent with stop bit low, then line held low for 3 bit times: one pulse with data 0x55 and o_frame_err=1; no further pulse until the line returns high; next 0xA5 received correctly.
REQ-035 UART_RX_PARITY_EN, PARITY_ODD=0: 0x03 sent with parity bit 1 gives o_parity_err=1 and data 0x03; with parity bit 0 it gives o_parity_err=0.
REQ-036 i_rst_n pulsed low during data bit 4: all outputs 0 within the reset; after release, 0xA5 received correctly and the partial frame is never reported.
REQ-037 Bit periods 8507 ns and 8853 ns, 0x3C sent 4 times back-to-back: 4 pulses, all data 0x3C, no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterised 16x-oversampling UART receiver with 3-sample majority voting per bit.
// Defining UART_RX_PARITY_EN adds one parity bit after the data bits (polarity from PARITY_ODD).
module uart_rx_param #(
    parameter int CLK_FREQ   = 125000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_srx,
    output logic [DATA_BITS-1:0] o_Rx_data,
    output logic                 o_Rx_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int OSR_DIV = int'((longint'(CLK_FREQ) + longint'(BAUD) * 8) / (longint'(BAUD) * 16));
    localparam int DIV_W   = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OSR_DIV - 1);

    // Sample n of a bit is the n-th oversample tick, i.e. counter value n-1.
    localparam logic [3:0] SMP_7    = 4'd6;
    localparam logic [3:0] SMP_8    = 4'd7;
    localparam logic [3:0] SMP_9    = 4'd8;
    localparam logic [3:0] SMP_LAST = 4'd15;

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || OSR_DIV < 1) begin : g_bad_cfg
        $error("uart_rx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state_q;
    logic [1:0]           sync_q;
    logic                 rx_prev_q;
    logic [DIV_W-1:0]     div_cnt_q;
    logic [3:0]           smp_cnt_q;
    logic [3:0]           bit_cnt_q;
    logic [1:0]           smp_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 ferr_acc_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 frame_err_q;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD_BIT = (PARITY_ODD != 0);
    logic                 par_acc_q;
    logic                 parity_err_q;
`endif

    logic rx_s;
    logic tick;
    logic mid;
    logic bit_end;
    logic maj;

    assign rx_s    = sync_q[1];
    assign tick    = (div_cnt_q == DIV_LAST);
    assign mid     = tick && (smp_cnt_q == SMP_9);
    assign bit_end = tick && (smp_cnt_q == SMP_LAST);
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            div_cnt_q    <= '0;
            smp_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            smp_q        <= '0;
            shift_q      <= '0;
            ferr_acc_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: later non-blocking writes in this block override these defaults (last write wins).
            sync_q      <= {sync_q[0], i_srx};
            rx_prev_q   <= rx_s;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (tick) begin
                div_cnt_q <= '0;
                smp_cnt_q <= smp_cnt_q + 4'd1;
                if (smp_cnt_q == SMP_7) smp_q[0] <= rx_s;
                if (smp_cnt_q == SMP_8) smp_q[1] <= rx_s;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    div_cnt_q  <= '0;
                    smp_cnt_q  <= '0;
                    bit_cnt_q  <= '0;
                    ferr_acc_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_acc_q  <= 1'b0;
`endif
                    if (rx_prev_q && !rx_s) state_q <= S_START;
                end
                S_START: begin
                    if (mid && maj) state_q <= S_IDLE;
                    else if (bit_end) state_q <= S_DATA;
                end
                S_DATA: begin
                    if (mid) begin
                        shift_q <= {maj, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                        par_acc_q <= par_acc_q ^ maj;
`endif
                    end
                    if (bit_end) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= S_PARITY;
`else
                            state_q   <= S_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (mid) par_acc_q <= par_acc_q ^ maj;
                    if (bit_end) state_q <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (mid) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            rx_valid_q  <= 1'b1;
                            rx_data_q   <= shift_q;
                            frame_err_q <= ferr_acc_q | ~maj;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_acc_q ^ PAR_ODD_BIT;
`endif
                            state_q     <= maj ? S_IDLE : S_WAIT_IDLE;
                        end else begin
                            ferr_acc_q <= ferr_acc_q | ~maj;
                        end
                    end
                    if (bit_end) bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                S_WAIT_IDLE: begin
                    if (rx_s) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_Rx_data   = rx_data_q;
    assign o_Rx_valid  = rx_valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule
